// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Select width and pointer increment live here so both modules agree.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic sel_t rr_next(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Round-robin pick: rotate requests so ptr is bit 0, take the lowest set bit,
// then rotate the one-hot grant back into requester order.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [3:0] req,
    input  sel_t       ptr,
    output logic       any,
    output sel_t       winner,
    output logic [3:0] grant
);

    logic [7:0] rot2;
    logic [7:0] gnt2;
    logic [3:0] rot;
    logic [3:0] grot;
    sel_t       off;

    always_comb begin
        rot2 = {req, req} >> ptr;
        rot  = rot2[3:0];
        off  = '0;
        grot = '0;
        if (rot[0]) begin
            off  = 2'd0;
            grot = 4'b0001;
        end else if (rot[1]) begin
            off  = 2'd1;
            grot = 4'b0010;
        end else if (rot[2]) begin
            off  = 2'd2;
            grot = 4'b0100;
        end else if (rot[3]) begin
            off  = 2'd3;
            grot = 4'b1000;
        end
        winner = off + ptr;
        gnt2   = {grot, grot} << ptr;
        grant  = gnt2[7:4];
        any    = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four valid/ready requesters share one W-bit AND-OR mux into a one-entry
// output register; round-robin pointer advances past each winner.
module rr_mux_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_vld,
    input  logic [W-1:0] req_data0,
    input  logic [W-1:0] req_data1,
    input  logic [W-1:0] req_data2,
    input  logic [W-1:0] req_data3,
    output logic [3:0]   req_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_rdy
);

    sel_t         ptr;
    sel_t         winner;
    logic         any;
    logic [3:0]   grant;
    logic         can_accept;
    logic         accept;
    logic [W-1:0] mux_data;

    rr_pick_4 u_pick (
        .req    (req_vld),
        .ptr    (ptr),
        .any    (any),
        .winner (winner),
        .grant  (grant)
    );

    assign can_accept = ~out_vld | out_rdy;
    assign req_rdy    = grant & {4{can_accept & any & ~rst}};
    assign accept     = |req_rdy;

    // Unselected lanes are forced to zero, so unknown data cannot leak through.
    assign mux_data = ({W{grant[0]}} & req_data0)
                    | ({W{grant[1]}} & req_data1)
                    | ({W{grant[2]}} & req_data2)
                    | ({W{grant[3]}} & req_data3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= mux_data;
            out_sel  <= winner;
            ptr      <= rr_next(winner);
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4 with hand-computed expectations.
module tb_rr_mux_arbiter_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_vld;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   req_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_rdy;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter_4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_data0 (d0),
        .req_data1 (d1),
        .req_data2 (d2),
        .req_data3 (d3),
        .req_rdy   (req_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_rdy   (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [W-1:0] d, input logic [1:0] s);
        chk({tag, ".vld"}, {7'd0, out_vld}, {7'd0, v});
        chk({tag, ".data"}, {4'd0, out_data}, {4'd0, d});
        chk({tag, ".sel"}, {6'd0, out_sel}, {6'd0, s});
    endtask

    initial begin
        rst     = 1'b1;
        req_vld = 4'b1111;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        out_rdy = 1'b1;
        tick();
        tick();
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk("rst.rdy", {4'd0, req_rdy}, 8'h00);

        // 1: single requester, ptr -> 3
        rst = 1'b0;
        req_vld = 4'b0100;
        settle();
        chk("t1.rdy", {4'd0, req_rdy}, 8'h04);
        tick();
        chk_out("t1.out", 1'b1, 4'hC, 2'd2);
        req_vld = 4'b1111;
        settle();
        chk("t1.ptr3", {4'd0, req_rdy}, 8'h08);
        tick();
        chk_out("t1.g3", 1'b1, 4'hD, 2'd3);

        // 2: all requesting, ptr=0: 0,1,2,3,0 back to back
        settle();
        chk("t2.rdy0", {4'd0, req_rdy}, 8'h01);
        tick();
        chk_out("t2.g0", 1'b1, 4'hA, 2'd0);
        chk("t2.rdy1", {4'd0, req_rdy}, 8'h02);
        tick();
        chk_out("t2.g1", 1'b1, 4'hB, 2'd1);
        chk("t2.rdy2", {4'd0, req_rdy}, 8'h04);
        tick();
        chk_out("t2.g2", 1'b1, 4'hC, 2'd2);
        chk("t2.rdy3", {4'd0, req_rdy}, 8'h08);
        tick();
        chk_out("t2.g3", 1'b1, 4'hD, 2'd3);
        tick();
        chk_out("t2.g0b", 1'b1, 4'hA, 2'd0);

        // 3: backpressure, FULL with A, ptr=1
        out_rdy = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("t3.rdy", {4'd0, req_rdy}, 8'h00);
            tick();
            chk_out("t3.hold", 1'b1, 4'hA, 2'd0);
        end
        out_rdy = 1'b1;
        settle();
        chk("t3.rdy1", {4'd0, req_rdy}, 8'h02);
        tick();
        chk_out("t3.refill", 1'b1, 4'hB, 2'd1);

        // 4: ptr=2 -> grant 2, then wrap 0, then 1
        req_vld = 4'b0100;
        tick();
        chk_out("t4.g2", 1'b1, 4'hC, 2'd2);
        req_vld = 4'b0011;
        settle();
        chk("t4.rdy0", {4'd0, req_rdy}, 8'h01);
        tick();
        chk_out("t4.g0", 1'b1, 4'hA, 2'd0);
        chk("t4.rdy1", {4'd0, req_rdy}, 8'h02);
        tick();
        chk_out("t4.g1", 1'b1, 4'hB, 2'd1);
        req_vld = 4'b0000;
        settle();
        chk("t4.rdy_none", {4'd0, req_rdy}, 8'h00);
        tick();
        chk_out("t4.drain", 1'b0, 4'hB, 2'd1);
        req_vld = 4'b1111;
        settle();
        chk("t4.ptr2", {4'd0, req_rdy}, 8'h04);
        tick();
        chk_out("t4.g2b", 1'b1, 4'hC, 2'd2);

        // 5: async reset during a stall
        req_vld = 4'b0000;
        out_rdy = 1'b0;
        tick();
        chk_out("t5.stall", 1'b1, 4'hC, 2'd2);
        #2;
        rst = 1'b1;
        req_vld = 4'b1111;
        #1;
        chk_out("t5.async", 1'b0, 4'h0, 2'd0);
        chk("t5.rdy_rst", {4'd0, req_rdy}, 8'h00);
        tick();
        rst = 1'b0;
        req_vld = 4'b1010;
        out_rdy = 1'b1;
        settle();
        chk("t5.rdy1", {4'd0, req_rdy}, 8'h02);
        tick();
        chk_out("t5.g1", 1'b1, 4'hB, 2'd1);

        // 6: unknown data on requester 3 never reaches the output
        rst = 1'b1;
        req_vld = 4'b0000;
        tick();
        rst = 1'b0;
        d3 = 'x;
        req_vld = 4'b0111;
        settle();
        for (int i = 0; i < 4; i++) begin
            logic [1:0]   es;
            logic [W-1:0] ed;
            es = 2'(i % 3);
            ed = (es == 2'd0) ? 4'hA : (es == 2'd1) ? 4'hB : 4'hC;
            chk("t6.rdy3", {7'd0, req_rdy[3]}, 8'h00);
            tick();
            chk("t6.known", {7'd0, $isunknown(out_data)}, 8'h00);
            chk_out("t6.g", 1'b1, ed, es);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
